// File: rtl/power_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : power_mon_pkg
//  Purpose  : Shared types, widths and helpers for the core-rail power
//             monitor (FSM state encoding, telemetry/power widths, overrun
//             counter saturation and hysteretic alarm evaluation).
//  Revision : 1.0  initial release
// ============================================================================
package power_mon_pkg;

    localparam int PWR_W = 32;   // power word, 10 uW LSB
    localparam int TEL_W = 16;   // telemetry word (voltage or current)
    localparam int OVR_W = 8;    // overrun counter width

    // Sample-processing sequence: capture, two products, accumulate, publish.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        ACC  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (&v) ? v : (v + OVR_W'(1));
    endfunction

    // Alarm with hysteresis: forced low until the window is full, then set
    // strictly above hi, cleared strictly below lo, held in between.
    function automatic logic hyst_flag(
        input logic             full,
        input logic [PWR_W-1:0] avg,
        input logic [PWR_W-1:0] hi,
        input logic [PWR_W-1:0] lo,
        input logic             cur
    );
        if (!full) begin
            return 1'b0;
        end else if (avg > hi) begin
            return 1'b1;
        end else if (avg < lo) begin
            return 1'b0;
        end
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul16.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mul16
//  Purpose  : 16x16 -> 32-bit unsigned shift-add multiplier, one partial
//             product per clock. The start edge latches the operands and
//             already folds in multiplier bit 0, so the 15 following edges
//             finish the product and done pulses 16 cycles after start.
//  Revision : 1.0  initial release
// ============================================================================
module seq_mul16
    import power_mon_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TEL_W-1:0] a,
    input  logic [TEL_W-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [PWR_W-1:0] p
);

    localparam logic [3:0] c_LAST_BIT = 4'd15;
    localparam logic [3:0] c_BIT_ONE  = 4'd1;

    logic [PWR_W-1:0] r_mcand;   // multiplicand, pre-shifted to the current bit weight
    logic [TEL_W-1:0] r_mplier;  // remaining multiplier bits, current bit in [0]
    logic [PWR_W-1:0] r_acc;
    logic [3:0]       r_bit;
    logic             r_busy;
    logic             r_done;

    // Shift-add iteration; start has priority and restarts the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_bit    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_mcand  <= {{(PWR_W-TEL_W-1){1'b0}}, a, 1'b0};
                r_mplier <= {1'b0, b[TEL_W-1:1]};
                r_acc    <= b[0] ? {{(PWR_W-TEL_W){1'b0}}, a} : '0;
                r_bit    <= c_BIT_ONE;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= {r_mcand[PWR_W-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[TEL_W-1:1]};
                r_bit    <= r_bit + c_BIT_ONE;
                if (r_bit == c_LAST_BIT) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_acc;

endmodule
`default_nettype wire

// File: rtl/rail_power_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : rail_power_monitor
//  Purpose  : Samples voltage/current telemetry of two core rails on a
//             periodic tick or on request, forms P = V*I per channel with one
//             shared sequential multiplier, keeps a 2^AVG_LOG2-sample moving
//             average per channel and raises hysteretic over-power alarms.
//  Revision : 1.0  initial release
// ============================================================================
module rail_power_monitor
    import power_mon_pkg::*;
#(
    parameter int SAMPLE_DIV   = 5_000_000,
    parameter int AVG_LOG2     = 3,
    parameter int PWR_HI_LIMIT = 1_000_000,
    parameter int PWR_LO_LIMIT = 900_000
) (
    input  logic             CLK_50,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             SAMPLE_REQ,
    input  logic [TEL_W-1:0] VOUT_S_0,
    input  logic [TEL_W-1:0] IOUT_S_0,
    input  logic [TEL_W-1:0] VOUT_S_1,
    input  logic [TEL_W-1:0] IOUT_S_1,
    output logic [PWR_W-1:0] PWR_0,
    output logic [PWR_W-1:0] PWR_1,
    output logic             PWR_VALID,
    output logic             AVG_READY,
    output logic             OVER_PWR_0,
    output logic             OVER_PWR_1,
    output logic [OVR_W-1:0] OVERRUN_CNT
);

    localparam int c_WIN    = 1 << AVG_LOG2;
    localparam int c_SUM_W  = PWR_W + AVG_LOG2;
    localparam int c_FILL_W = AVG_LOG2 + 1;
    localparam int c_CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(SAMPLE_DIV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [AVG_LOG2-1:0] c_WP_ONE    = AVG_LOG2'(1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(c_WIN);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [PWR_W-1:0]    c_HI        = PWR_W'(PWR_HI_LIMIT);
    localparam logic [PWR_W-1:0]    c_LO        = PWR_W'(PWR_LO_LIMIT);

    // ---------------------------------------------------------------- signals
    state_t              r_state;
    state_t              w_state_next;

    logic [c_CNT_W-1:0]  r_tick_cnt;
    logic                w_tick;
    logic                w_trig;
    logic                w_accept;
    logic                w_drop;

    logic [TEL_W-1:0]    r_v0;
    logic [TEL_W-1:0]    r_i0;
    logic [TEL_W-1:0]    r_v1;
    logic [TEL_W-1:0]    r_i1;
    logic                r_kick;     // first MUL0 cycle: launch the channel-0 product

    logic                w_mul_start;
    logic                w_mul_busy;
    logic                w_mul_done;
    logic [TEL_W-1:0]    w_mul_a;
    logic [TEL_W-1:0]    w_mul_b;
    logic [PWR_W-1:0]    w_mul_p;
    logic [PWR_W-1:0]    r_p0;

    logic [PWR_W-1:0]    r_buf0 [c_WIN];
    logic [PWR_W-1:0]    r_buf1 [c_WIN];
    logic [AVG_LOG2-1:0] r_wp;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_FILL_W-1:0] w_fill_next;
    logic                w_full_next;
    logic [c_SUM_W-1:0]  r_sum0;
    logic [c_SUM_W-1:0]  r_sum1;
    logic [c_SUM_W-1:0]  w_sum0_next;
    logic [c_SUM_W-1:0]  w_sum1_next;
    logic [PWR_W-1:0]    w_avg0_next;
    logic [PWR_W-1:0]    w_avg1_next;

    logic [PWR_W-1:0]    r_pwr0;
    logic [PWR_W-1:0]    r_pwr1;
    logic                r_pwr_valid;
    logic                r_avg_ready;
    logic                r_over0;
    logic                r_over1;
    logic [OVR_W-1:0]    r_overrun;

    // ------------------------------------------------------------ tick / trig
    // Free-running sample divider; held at zero whenever sampling is disabled.
    always_ff @(posedge CLK_50) begin
        if (RESET || !ENABLE) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == c_CNT_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_CNT_ONE;
        end
    end

    assign w_tick   = ENABLE && (r_tick_cnt == c_CNT_LAST);
    assign w_trig   = w_tick || SAMPLE_REQ;
    // Only a genuinely idle sequencer takes a new sample; the OUT cycle counts as busy.
    assign w_accept = w_trig && (r_state == IDLE);
    assign w_drop   = w_trig && (r_state != IDLE);

    // --------------------------------------------------------------------- FSM
    // State register.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: wait on the multiplier for each channel, then one cycle each for ACC/OUT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_trig)     w_state_next = MUL0;
            MUL0: if (w_mul_done) w_state_next = MUL1;
            MUL1: if (w_mul_done) w_state_next = ACC;
            ACC:                  w_state_next = OUT;
            OUT:                  w_state_next = IDLE;
            default:              w_state_next = IDLE;
        endcase
    end

    // Capture the telemetry snapshot; later input changes do not affect this sample.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_v0   <= '0;
            r_i0   <= '0;
            r_v1   <= '0;
            r_i1   <= '0;
            r_kick <= 1'b0;
        end else begin
            r_kick <= w_accept;
            if (w_accept) begin
                r_v0 <= VOUT_S_0;
                r_i0 <= IOUT_S_0;
                r_v1 <= VOUT_S_1;
                r_i1 <= IOUT_S_1;
            end
        end
    end

    // ------------------------------------------------------------- multiplier
    // Channel 0 launches on the first MUL0 cycle; channel 1 launches back-to-back
    // on the channel-0 done pulse so the two products take exactly 32 cycles.
    assign w_mul_start = (r_kick || ((r_state == MUL0) && w_mul_done)) && !w_mul_busy;
    assign w_mul_a     = r_kick ? r_v0 : r_v1;
    assign w_mul_b     = r_kick ? r_i0 : r_i1;

    seq_mul16 u_mul (
        .clk   (CLK_50),
        .rst   (RESET),
        .start (w_mul_start),
        .a     (w_mul_a),
        .b     (w_mul_b),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    // Park the channel-0 product; channel 1 is read straight from the multiplier,
    // which holds its result until the next start.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_p0 <= '0;
        end else if ((r_state == MUL0) && w_mul_done) begin
            r_p0 <= w_mul_p;
        end
    end

    // --------------------------------------------------------- moving average
    // Running-sum update: drop the oldest slot, add the new product.
    always_comb begin
        w_sum0_next = r_sum0 - {{AVG_LOG2{1'b0}}, r_buf0[r_wp]} + {{AVG_LOG2{1'b0}}, r_p0};
        w_sum1_next = r_sum1 - {{AVG_LOG2{1'b0}}, r_buf1[r_wp]} + {{AVG_LOG2{1'b0}}, w_mul_p};
        w_fill_next = (r_fill == c_FILL_FULL) ? r_fill : (r_fill + c_FILL_ONE);
        w_full_next = (w_fill_next == c_FILL_FULL);
        w_avg0_next = w_sum0_next[c_SUM_W-1:AVG_LOG2];
        w_avg1_next = w_sum1_next[c_SUM_W-1:AVG_LOG2];
    end

    // Window storage, sums, write pointer and fill level; written only in ACC.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            for (int k = 0; k < c_WIN; k++) begin
                r_buf0[k] <= '0;
                r_buf1[k] <= '0;
            end
            r_sum0 <= '0;
            r_sum1 <= '0;
            r_wp   <= '0;
            r_fill <= '0;
        end else if (r_state == ACC) begin
            r_buf0[r_wp] <= r_p0;
            r_buf1[r_wp] <= w_mul_p;
            r_sum0       <= w_sum0_next;
            r_sum1       <= w_sum1_next;
            r_wp         <= r_wp + c_WP_ONE;
            r_fill       <= w_fill_next;
        end
    end

    // Published results are loaded on the ACC->OUT edge from the new sums, so
    // PWR_VALID is high exactly while the sequencer sits in OUT.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_pwr0      <= '0;
            r_pwr1      <= '0;
            r_pwr_valid <= 1'b0;
            r_avg_ready <= 1'b0;
            r_over0     <= 1'b0;
            r_over1     <= 1'b0;
        end else begin
            r_pwr_valid <= 1'b0;
            if (r_state == ACC) begin
                r_pwr0      <= w_avg0_next;
                r_pwr1      <= w_avg1_next;
                r_pwr_valid <= 1'b1;
                r_avg_ready <= w_full_next;
                r_over0     <= hyst_flag(w_full_next, w_avg0_next, c_HI, c_LO, r_over0);
                r_over1     <= hyst_flag(w_full_next, w_avg1_next, c_HI, c_LO, r_over1);
            end
        end
    end

    // Count triggers that arrive while a sample is still in progress.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            r_overrun <= '0;
        end else if (w_drop) begin
            r_overrun <= sat_inc(r_overrun);
        end
    end

    assign PWR_0       = r_pwr0;
    assign PWR_1       = r_pwr1;
    assign PWR_VALID   = r_pwr_valid;
    assign AVG_READY   = r_avg_ready;
    assign OVER_PWR_0  = r_over0;
    assign OVER_PWR_1  = r_over1;
    assign OVERRUN_CNT = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rail_power_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rail_power_monitor
//  Purpose  : Scoreboard bench for rail_power_monitor. Stimulus pushes the
//             expected result of every accepted sample into a queue; a
//             monitor pops and compares on each PWR_VALID pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rail_power_monitor;

    localparam int    DIV = 64;
    localparam int    N   = 8;
    localparam longint HI = 1_000_000;
    localparam longint LO = 900_000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req;
    logic [15:0] v0, i0, v1, i1;
    logic [31:0] pwr0, pwr1;
    logic        valid, ready, ov0, ov1;
    logic [7:0]  ovr;

    always #5 clk = ~clk;

    rail_power_monitor #(
        .SAMPLE_DIV   (DIV),
        .AVG_LOG2     (3),
        .PWR_HI_LIMIT (1_000_000),
        .PWR_LO_LIMIT (900_000)
    ) dut (
        .CLK_50      (clk),
        .RESET       (rst),
        .ENABLE      (en),
        .SAMPLE_REQ  (req),
        .VOUT_S_0    (v0),
        .IOUT_S_0    (i0),
        .VOUT_S_1    (v1),
        .IOUT_S_1    (i1),
        .PWR_0       (pwr0),
        .PWR_1       (pwr1),
        .PWR_VALID   (valid),
        .AVG_READY   (ready),
        .OVER_PWR_0  (ov0),
        .OVER_PWR_1  (ov1),
        .OVERRUN_CNT (ovr)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint p0;
        longint p1;
        bit     rdy;
        bit     o0;
        bit     o1;
        int     at;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_valid = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------- reference model
    longint mb0[N];
    longint mb1[N];
    longint ms0, ms1;
    int     mwp, mfill;
    bit     mo0, mo1;

    function automatic bit hyst(input bit full, input longint avg, input bit cur);
        if (!full)    return 1'b0;
        if (avg > HI) return 1'b1;
        if (avg < LO) return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mb0[k] = 0;
            mb1[k] = 0;
        end
        ms0 = 0; ms1 = 0; mwp = 0; mfill = 0; mo0 = 1'b0; mo1 = 1'b0;
    endtask

    task automatic model_push(input longint pa, input longint pb, input int at);
        exp_t e;
        ms0 = ms0 - mb0[mwp] + pa;
        ms1 = ms1 - mb1[mwp] + pb;
        mb0[mwp] = pa;
        mb1[mwp] = pb;
        mwp = (mwp + 1) % N;
        if (mfill < N) mfill++;
        e.p0  = ms0 / N;
        e.p1  = ms1 / N;
        e.rdy = (mfill == N);
        mo0   = hyst(e.rdy, e.p0, mo0);
        mo1   = hyst(e.rdy, e.p1, mo1);
        e.o0  = mo0;
        e.o1  = mo1;
        e.at  = at;
        q.push_back(e);
    endtask

    // ------------------------------------------------------------------ monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (valid === 1'b1) begin
            n_valid++;
            if (q.size() == 0) begin
                chk("unexpected PWR_VALID at cycle", cyc, -1);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.at);
                chk("PWR_0", pwr0, e.p0);
                chk("PWR_1", pwr1, e.p1);
                chk("AVG_READY", ready, e.rdy);
                chk("OVER_PWR_0", ov0, e.o0);
                chk("OVER_PWR_1", ov1, e.o1);
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        if (q.size() != 0) begin
            chk("drain timeout, pending results", q.size(), 0);
            q.delete();
        end
        step();
    endtask

    task automatic set_in(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        v0 = a; i0 = b; v1 = c; i1 = d;
    endtask

    // One manual sample; inputs are scrambled right after capture.
    task automatic sample(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        set_in(a, b, c, d);
        req = 1'b1;
        model_push(longint'(a) * longint'(b), longint'(c) * longint'(d), cyc + 35);
        step();
        req = 1'b0;
        set_in(16'h1357, 16'h2468, 16'h0F0F, 16'h7777);
        drain(60);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " PWR_0"}, pwr0, 0);
        chk({tag, " PWR_1"}, pwr1, 0);
        chk({tag, " PWR_VALID"}, valid, 0);
        chk({tag, " AVG_READY"}, ready, 0);
        chk({tag, " OVER_PWR_0"}, ov0, 0);
        chk({tag, " OVER_PWR_1"}, ov1, 0);
        chk({tag, " OVERRUN_CNT"}, ovr, 0);
    endtask

    initial begin : stim
        int t0;
        int nv;
        rst = 1'b1; en = 1'b0; req = 1'b0;
        set_in(16'd0, 16'd0, 16'd0, 16'd0);
        model_reset();
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Test 1: single request
        sample(16'd100, 16'd2500, 16'd330, 16'd1000);
        chk("t1 PWR_0", pwr0, 31250);
        chk("t1 PWR_1", pwr1, 41250);
        chk("t1 AVG_READY", ready, 0);

        // Test 2: fill the window
        for (int k = 0; k < 7; k++) sample(16'd100, 16'd2500, 16'd330, 16'd1000);
        chk("t2 PWR_0", pwr0, 250000);
        chk("t2 PWR_1", pwr1, 330000);
        chk("t2 AVG_READY", ready, 1);
        chk("t2 OVER_PWR_0", ov0, 0);

        // Test 3: ramp above HI, then drop and watch hysteresis
        for (int k = 0; k < 8; k++) sample(16'd500, 16'd2500, 16'd330, 16'd1000);
        chk("t3 PWR_0 high", pwr0, 1250000);
        chk("t3 OVER_PWR_0 set", ov0, 1);
        for (int k = 0; k < 2; k++) sample(16'd500, 16'd0, 16'd330, 16'd1000);
        chk("t3 PWR_0 hold", pwr0, 937500);
        chk("t3 OVER_PWR_0 hold", ov0, 1);
        sample(16'd500, 16'd0, 16'd330, 16'd1000);
        chk("t3 PWR_0 low", pwr0, 781250);
        chk("t3 OVER_PWR_0 clear", ov0, 0);

        // Test 4: requests at T, T+10, T+35
        chk("t4 OVERRUN_CNT start", ovr, 0);
        nv = n_valid;
        set_in(16'd100, 16'd2500, 16'd330, 16'd1000);
        t0 = cyc;
        req = 1'b1;
        model_push(250000, 330000, t0 + 35);
        step();
        req = 1'b0;
        go_to(t0 + 10); req = 1'b1; step(); req = 1'b0;
        go_to(t0 + 35); req = 1'b1; step(); req = 1'b0;
        drain(60);
        go_to(cyc + 40);
        chk("t4 OVERRUN_CNT", ovr, 2);
        chk("t4 PWR_VALID count", n_valid - nv, 1);

        // Test 4b: continuous request, 9 accepted samples, 315 drops -> saturate
        t0 = cyc;
        req = 1'b1;
        for (int r = 0; r < 9; r++) model_push(250000, 330000, t0 + 36 * r + 35);
        go_to(t0 + 324);
        req = 1'b0;
        drain(100);
        chk("t4 OVERRUN_CNT saturated", ovr, 255);

        // Test 5: free-running tick, reset mid-computation
        set_in(16'd200, 16'd1500, 16'd120, 16'd4000);
        t0 = cyc;
        en = 1'b1;
        model_push(300000, 480000, t0 + 98);
        model_push(300000, 480000, t0 + 162);
        go_to(t0 + 211);
        chk("t5 both periodic results seen", q.size(), 0);
        rst = 1'b1;
        en  = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        check_all_zero("t5 after reset");
        go_to(cyc + 80);
        sample(16'd200, 16'd1500, 16'd120, 16'd4000);
        chk("t5 PWR_0 first after reset", pwr0, 37500);
        chk("t5 PWR_1 first after reset", pwr1, 60000);
        chk("t5 AVG_READY", ready, 0);

        // Test 6: full-scale inputs, no wrap
        for (int k = 0; k < 8; k++) sample(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        chk("t6 PWR_0", pwr0, 64'h0000_0000_FFFE_0001);
        chk("t6 PWR_1", pwr1, 64'h0000_0000_FFFE_0001);
        chk("t6 OVER_PWR_0", ov0, 1);
        chk("t6 OVER_PWR_1", ov1, 1);
        chk("t6 AVG_READY", ready, 1);

        drain(60);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
